// File: rtl/pool_window_stream.sv
// rtl/pool_window_stream.sv - streaming WINxWIN non-overlapping max/avg pooling engine
// Average pooling is compiled in only when POOL_AVG_EN is defined; default build is max-only.
module pool_window_stream #(
  parameter int PIXEL_WIDTH = 10,
  parameter int WIN         = 2,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   mode_i,
  input  logic                   px_valid_i,
  input  logic [PIXEL_WIDTH-1:0] px_i,
  output logic [PIXEL_WIDTH-1:0] px_o,
  output logic                   px_valid_o,
  output logic                   busy_o,
  output logic                   frame_done_o
);

  localparam int LOG2W = $clog2(WIN);
`ifdef POOL_AVG_EN
  localparam int SH    = 2 * LOG2W;
  localparam int ACC_W = PIXEL_WIDTH + SH;
`else
  localparam int ACC_W = PIXEL_WIDTH;
`endif
  localparam int NCOL = IMG_WIDTH / WIN;
  localparam int CW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int IW   = (NCOL > 1) ? $clog2(NCOL) : 1;

  localparam logic [CW-1:0]    COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [LOG2W-1:0] W_LAST   = LOG2W'(WIN - 1);

  if (WIN < 2 || WIN > 8 || (WIN & (WIN - 1)) != 0) begin : g_bad_win
    $error("pool_window_stream: WIN must be a power of two in 2..8");
  end
  if ((IMG_WIDTH % WIN) != 0 || (IMG_HEIGHT % WIN) != 0) begin : g_bad_img
    $error("pool_window_stream: IMG_WIDTH and IMG_HEIGHT must be multiples of WIN");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic signed [ACC_W-1:0] hacc;
  logic signed [ACC_W-1:0] lbuf [NCOL];
  logic signed [ACC_W-1:0] px_ext, h_new, v_new, lb_rd;
  logic [PIXEL_WIDTH-1:0]  pool_val;
  logic [IW-1:0]           col_idx;
  logic [LOG2W-1:0]        wcol, wrow;
  logic                    accept;

`ifdef POOL_AVG_EN
  logic avg_q;
`else
  logic unused_mode;
  assign unused_mode = mode_i;
`endif

  function automatic logic signed [ACC_W-1:0] smax(input logic signed [ACC_W-1:0] a,
                                                   input logic signed [ACC_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign px_ext  = ACC_W'($signed(px_i));
  assign col_idx = IW'(col >> LOG2W);
  assign wcol    = col[LOG2W-1:0];
  assign wrow    = row[LOG2W-1:0];
  assign accept  = (state == S_RUN) && px_valid_i && !start_i;

  // Horizontal result restarts at each window's first column; the vertical
  // merge takes the line-buffer partial unless this is the window's first row.
  always_comb begin
    lb_rd = lbuf[col_idx];
    h_new = px_ext;
    if (wcol != '0) h_new = smax(hacc, px_ext);
`ifdef POOL_AVG_EN
    if (avg_q && wcol != '0) h_new = hacc + px_ext;
`endif
    v_new = h_new;
    if (wrow != '0) v_new = smax(lb_rd, h_new);
`ifdef POOL_AVG_EN
    if (avg_q && wrow != '0) v_new = lb_rd + h_new;
    pool_val = avg_q ? PIXEL_WIDTH'(v_new >>> SH) : v_new[PIXEL_WIDTH-1:0];
`else
    pool_val = v_new;
`endif
  end

  // The last row of a window never needs storing; its result goes straight out.
  always_ff @(posedge clk_i) begin
    if (accept && wcol == W_LAST && wrow != W_LAST) lbuf[col_idx] <= v_new;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= S_IDLE;
      col          <= '0;
      row          <= '0;
      hacc         <= '0;
      px_o         <= '0;
      px_valid_o   <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
`ifdef POOL_AVG_EN
      avg_q        <= 1'b0;
`endif
    end else begin
      px_valid_o   <= 1'b0;
      frame_done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state  <= S_RUN;
            busy_o <= 1'b1;
            col    <= '0;
            row    <= '0;
`ifdef POOL_AVG_EN
            avg_q  <= mode_i;
`endif
          end
        end
        S_RUN: begin
          if (start_i) begin
            col   <= '0;
            row   <= '0;
`ifdef POOL_AVG_EN
            avg_q <= mode_i;
`endif
          end else if (px_valid_i) begin
            hacc <= h_new;
            if (wcol == W_LAST && wrow == W_LAST) begin
              px_o       <= pool_val;
              px_valid_o <= 1'b1;
            end
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row          <= '0;
                state        <= S_DONE;
                busy_o       <= 1'b0;
                frame_done_o <= 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_window_stream.sv
// tb/tb_pool_window_stream.sv - directed and table-driven bench for pool_window_stream
module tb_pool_window_stream;
  localparam int PW = 10;

  logic clk = 1'b0;
  logic rst, start, mode, pv;
  logic [PW-1:0] px;
  logic [PW-1:0] po_s, po_l;
  logic pvo_s, pvo_l, busy_s, busy_l, fd_s, fd_l;

  always #5 clk = ~clk;

  pool_window_stream #(.PIXEL_WIDTH(PW), .WIN(2), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_s (
    .clk_i(clk), .reset_i(rst), .start_i(start), .mode_i(mode), .px_valid_i(pv), .px_i(px),
    .px_o(po_s), .px_valid_o(pvo_s), .busy_o(busy_s), .frame_done_o(fd_s));

  pool_window_stream #(.PIXEL_WIDTH(PW), .WIN(2), .IMG_WIDTH(28), .IMG_HEIGHT(28)) dut_l (
    .clk_i(clk), .reset_i(rst), .start_i(start), .mode_i(mode), .px_valid_i(pv), .px_i(px),
    .px_o(po_l), .px_valid_o(pvo_l), .busy_o(busy_l), .frame_done_o(fd_l));

  int checks = 0;
  int errors = 0;
  int q_s[$];
  int q_l[$];
  int fd_cnt_s = 0;
  int fd_cnt_l = 0;
  logic fd_at_last_s = 1'b0;

  always @(negedge clk) begin
    if (pvo_s) begin
      q_s.push_back(int'($signed(po_s)));
      fd_at_last_s = fd_s;
    end
    if (fd_s) fd_cnt_s++;
    if (pvo_l) q_l.push_back(int'($signed(po_l)));
    if (fd_l) fd_cnt_l++;
  end

  typedef struct {
    int base; int step;
    int i0; int v0; int i1; int v1;
    int e0; int e1; int e2; int e3;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int v);
    pv = 1'b1;
    px = PW'(v);
    tick();
    pv = 1'b0;
  endtask

  task automatic clear_mon();
    q_s.delete();
    q_l.delete();
    fd_cnt_s = 0;
    fd_cnt_l = 0;
    fd_at_last_s = 1'b0;
  endtask

  task automatic send_ramp();
    for (int i = 0; i < 16; i++) send(i);
  endtask

  task automatic check_four(input string name, input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check($sformatf("%s count", name), q_s.size(), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s px[%0d]", name, k), (q_s.size() > k) ? q_s[k] : 9999, e[k]);
    check($sformatf("%s frame_done count", name), fd_cnt_s, 1);
    check($sformatf("%s frame_done with last px", name), int'(fd_at_last_s), 1);
  endtask

  function automatic int vpx(input vec_t v, input int i);
    if (i == v.i0) return v.v0;
    if (i == v.i1) return v.v1;
    return v.base + v.step * i;
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int img[784];
    int expl[196];
    int avg_px[16];
    int m;

    vecs[0] = '{0, 1, -1, 0, -1, 0, 5, 7, 13, 15};
    vecs[1] = '{-1, -1, -1, 0, -1, 0, -1, -3, -9, -11};
    vecs[2] = '{-100, 0, 0, 12, 7, 300, 12, 300, -100, -100};
    vecs[3] = '{-512, 0, 3, 511, -1, 0, -512, 511, -512, -512};
    vecs[4] = '{100, 0, 13, 101, 10, -512, 100, 100, 101, 100};

    rst = 1'b1; start = 1'b0; mode = 1'b0; pv = 1'b0; px = '0;
    tick(); tick();
    check("reset px_o", int'(po_s), 0);
    check("reset px_valid_o", int'(pvo_s), 0);
    check("reset busy_o", int'(busy_s), 0);
    check("reset frame_done_o", int'(fd_s), 0);
    rst = 1'b0;
    tick();

    // Pixels offered while idle must be ignored
    clear_mon();
    pv = 1'b1; px = PW'(100);
    repeat (5) tick();
    pv = 1'b0;
    tick();
    check("idle outputs small", q_s.size(), 0);
    check("idle outputs large", q_l.size(), 0);
    check("idle busy", int'(busy_s), 0);

    for (int v = 0; v < 5; v++) begin
      clear_mon();
      pulse_start();
      check($sformatf("vec%0d busy in run", v), int'(busy_s), 1);
      for (int i = 0; i < 16; i++) send(vpx(vecs[v], i));
      repeat (3) tick();
      check_four($sformatf("vec%0d", v), vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3);
      check($sformatf("vec%0d busy after", v), int'(busy_s), 0);
    end

`ifdef POOL_AVG_EN
    avg_px = '{4, 8, -1, -2, 12, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    clear_mon();
    mode = 1'b1;
    pulse_start();
    mode = 1'b0;
    for (int i = 0; i < 16; i++) send(avg_px[i]);
    repeat (3) tick();
    check_four("avg", 10, -1, 0, 0);
`endif

    // Restart mid-frame after 10 pixels, then a clean ramp frame
    clear_mon();
    pulse_start();
    for (int i = 0; i < 10; i++) send(500);
    tick();
    clear_mon();
    pulse_start();
    send_ramp();
    repeat (3) tick();
    check_four("restart", 5, 7, 13, 15);

    // Asynchronous reset in the middle of a window
    clear_mon();
    pulse_start();
    for (int i = 0; i < 6; i++) send(i);
    tick();
    check("pre-reset px_o", int'($signed(po_s)), 5);
    clear_mon();
    pv = 1'b1; px = PW'(6);
    #2;
    rst = 1'b1;
    #1;
    check("async reset px_o", int'(po_s), 0);
    check("async reset px_valid_o", int'(pvo_s), 0);
    check("async reset busy_o", int'(busy_s), 0);
    check("async reset frame_done_o", int'(fd_s), 0);
    pv = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset no pulses", q_s.size(), 0);
    check("reset no frame_done", fd_cnt_s, 0);
    pulse_start();
    send_ramp();
    repeat (3) tick();
    check_four("post-reset", 5, 7, 13, 15);

    // 28x28 frame with random idle gaps against a direct 2x2 max model
    for (int i = 0; i < 784; i++) img[i] = int'($urandom_range(0, 1023)) - 512;
    for (int r = 0; r < 14; r++)
      for (int c = 0; c < 14; c++) begin
        m = img[(2*r)*28 + 2*c];
        if (img[(2*r)*28 + 2*c + 1] > m) m = img[(2*r)*28 + 2*c + 1];
        if (img[(2*r+1)*28 + 2*c] > m) m = img[(2*r+1)*28 + 2*c];
        if (img[(2*r+1)*28 + 2*c + 1] > m) m = img[(2*r+1)*28 + 2*c + 1];
        expl[r*14 + c] = m;
      end
    clear_mon();
    pulse_start();
    for (int i = 0; i < 784; i++) begin
      while ($urandom_range(0, 9) < 3) tick();
      send(img[i]);
    end
    repeat (4) tick();
    check("large count", q_l.size(), 196);
    for (int k = 0; k < 196; k++)
      check($sformatf("large px[%0d]", k), (q_l.size() > k) ? q_l[k] : 9999, expl[k]);
    check("large frame_done count", fd_cnt_l, 1);
    check("large busy after", int'(busy_l), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
